// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core (with helper uart_core_fifo)
//  Description : 8N1 UART with a first-word-fall-through RX FIFO and a TX FIFO.
//                Receiver samples at bit centres from a synchronized RX line;
//                transmitter drives TX from a register, back-to-back frames.
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_core_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  logic [7:0] i_wdata,
   input  logic       i_pop,
   output logic [7:0] o_rdata,
   output logic       o_empty,
   output logic       o_full
);
   localparam int              C_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(DEPTH);
   localparam logic [C_AW-1:0] C_ONE  = C_AW'(1);

   logic [7:0]      r_mem [DEPTH];
   logic [C_AW-1:0] r_wr_ptr;
   logic [C_AW-1:0] r_rd_ptr;
   logic [C_AW:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   assign w_do_push = i_push && (r_count != C_FULL);
   assign w_do_pop  = i_pop && (r_count != '0);
   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == C_FULL);
   // Head is presented combinationally; zero while empty so stale data never leaks.
   assign o_rdata   = o_empty ? 8'h00 : r_mem[r_rd_ptr];

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + C_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_ONE;
         if (w_do_push && !w_do_pop)      r_count <= r_count + (C_AW + 1)'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - (C_AW + 1)'(1);
      end
   end
endmodule

module uart_core #(
   parameter int C_BAUDRATE    = 115200,
   parameter int C_SYSTEM_FREQ = 50000000,
   parameter int C_FIFO_DEPTH  = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       RX,
   input  logic       Enable_rx,
   input  logic       rd_uart_en,
   output logic [7:0] RX_data,
   output logic       Empty,
   input  logic [7:0] TX_data,
   input  logic       wr_uart_en,
   input  logic       Enable_tx,
   output logic       Full,
   output logic       TX
);
   localparam int               C_BIT       = C_SYSTEM_FREQ / C_BAUDRATE;
   localparam int               C_HALF      = C_BIT / 2;
   localparam int               C_CW        = $clog2(C_BIT + 1);
   localparam logic [C_CW-1:0]  C_BIT_LAST  = C_CW'(C_BIT - 1);
   localparam logic [C_CW-1:0]  C_HALF_LAST = C_CW'(C_HALF - 1);
   localparam logic [C_CW-1:0]  C_CNT_ONE   = C_CW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // ------------------------------------------------------------------ RX --
   logic            r_rx_meta, r_rx_sync, r_rx_prev;
   logic [1:0]      r_rx_state, w_rx_next;
   logic [C_CW-1:0] r_rx_cnt;
   logic [2:0]      r_rx_bit;
   logic [7:0]      r_rx_shift;
   logic            w_rx_fall, w_rx_half_done, w_rx_bit_done;
   logic            w_rx_sample, w_rx_push, w_rx_cnt_clr, w_rx_full;

   assign w_rx_fall      = r_rx_prev & ~r_rx_sync;
   assign w_rx_half_done = (r_rx_cnt == C_HALF_LAST);
   assign w_rx_bit_done  = (r_rx_cnt == C_BIT_LAST);

   // Two-flop synchronizer plus one history flop for start-edge detection.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= RX;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Receiver state register.
   always_ff @(posedge Clk) begin
      if (Reset) r_rx_state <= S_IDLE;
      else       r_rx_state <= w_rx_next;
   end

   // Receiver next-state; disabling the receiver aborts any frame.
   always_comb begin
      w_rx_next = r_rx_state;
      if (!Enable_rx) begin
         w_rx_next = S_IDLE;
      end else begin
         case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_half_done) w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_bit_done && (r_rx_bit == 3'd7)) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_bit_done) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
         endcase
      end
   end

   // Receiver strobes: data sampling, FIFO push on a good stop bit, counter clear.
   always_comb begin
      w_rx_sample  = Enable_rx && (r_rx_state == S_DATA) && w_rx_bit_done;
      w_rx_push    = Enable_rx && (r_rx_state == S_STOP) && w_rx_bit_done &&
                     r_rx_sync && !w_rx_full;
      w_rx_cnt_clr = !Enable_rx || (r_rx_state == S_IDLE) ||
                     ((r_rx_state == S_START) && w_rx_half_done) ||
                     ((r_rx_state != S_START) && w_rx_bit_done);
   end

   // Receiver baud counter, bit index and LSB-first shift register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_cnt <= w_rx_cnt_clr ? '0 : r_rx_cnt + C_CNT_ONE;
         if (r_rx_state == S_IDLE || r_rx_state == S_START) begin
            r_rx_bit <= '0;
         end else if (w_rx_sample) begin
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
         end
      end
   end

   uart_core_fifo #(.DEPTH(C_FIFO_DEPTH)) u_rx_fifo (
      .clk     (Clk),
      .rst     (Reset),
      .i_push  (w_rx_push),
      .i_wdata (r_rx_shift),
      .i_pop   (rd_uart_en),
      .o_rdata (RX_data),
      .o_empty (Empty),
      .o_full  (w_rx_full)
   );

   // ------------------------------------------------------------------ TX --
   logic [1:0]      r_tx_state, w_tx_next;
   logic [C_CW-1:0] r_tx_cnt;
   logic [2:0]      r_tx_bit;
   logic [7:0]      r_tx_shift;
   logic            r_tx;
   logic [7:0]      w_tx_head;
   logic            w_tx_empty, w_tx_ready, w_tx_bit_done, w_tx_pop, w_tx_cnt_clr;

   assign w_tx_ready    = Enable_tx && !w_tx_empty;
   assign w_tx_bit_done = (r_tx_cnt == C_BIT_LAST);
   assign TX            = r_tx;

   uart_core_fifo #(.DEPTH(C_FIFO_DEPTH)) u_tx_fifo (
      .clk     (Clk),
      .rst     (Reset),
      .i_push  (wr_uart_en),
      .i_wdata (TX_data),
      .i_pop   (w_tx_pop),
      .o_rdata (w_tx_head),
      .o_empty (w_tx_empty),
      .o_full  (Full)
   );

   // Transmitter state register.
   always_ff @(posedge Clk) begin
      if (Reset) r_tx_state <= S_IDLE;
      else       r_tx_state <= w_tx_next;
   end

   // Transmitter next-state; the end of a stop bit chains straight into the next start.
   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (w_tx_ready) w_tx_next = S_START;
         S_START: if (w_tx_bit_done) w_tx_next = S_DATA;
         S_DATA:  if (w_tx_bit_done && (r_tx_bit == 3'd7)) w_tx_next = S_STOP;
         S_STOP:  if (w_tx_bit_done) w_tx_next = w_tx_ready ? S_START : S_IDLE;
         default: w_tx_next = S_IDLE;
      endcase
   end

   // Transmitter strobes: FIFO pop on frame launch, counter clear per bit.
   always_comb begin
      w_tx_pop     = w_tx_ready && ((r_tx_state == S_IDLE) ||
                                    ((r_tx_state == S_STOP) && w_tx_bit_done));
      w_tx_cnt_clr = (r_tx_state == S_IDLE) || w_tx_bit_done;
   end

   // Transmitter baud counter, shift register and registered line driver.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx_cnt <= w_tx_cnt_clr ? '0 : r_tx_cnt + C_CNT_ONE;
         if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
         end else if (w_tx_bit_done) begin
            case (r_tx_state)
               S_START: r_tx <= r_tx_shift[0];
               S_DATA: begin
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_bit   <= r_tx_bit + 3'd1;
                  r_tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
               end
               default: r_tx <= 1'b1;
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_core
//  Description : Self-checking bench for uart_core. Serial RX frames are built
//                from byte values; TX frames are decoded at bit centres and
//                compared against byte queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;
   localparam int C_BAUDRATE    = 3125000;
   localparam int C_SYSTEM_FREQ = 50000000;
   localparam int C_FIFO_DEPTH  = 16;
   localparam int BIT           = C_SYSTEM_FREQ / C_BAUDRATE;   // 16 clocks

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       RX = 1'b1;
   logic       Enable_rx = 1'b0;
   logic       rd_uart_en = 1'b0;
   logic [7:0] TX_data = 8'h00;
   logic       wr_uart_en = 1'b0;
   logic       Enable_tx = 1'b0;
   logic [7:0] RX_data;
   logic       Empty, Full, TX;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   logic [7:0] rx_model[$];
   logic [7:0] tx_model[$];

   uart_core #(
      .C_BAUDRATE(C_BAUDRATE), .C_SYSTEM_FREQ(C_SYSTEM_FREQ), .C_FIFO_DEPTH(C_FIFO_DEPTH)
   ) dut (
      .Clk(Clk), .Reset(Reset), .RX(RX), .Enable_rx(Enable_rx), .rd_uart_en(rd_uart_en),
      .RX_data(RX_data), .Empty(Empty), .TX_data(TX_data), .wr_uart_en(wr_uart_en),
      .Enable_tx(Enable_tx), .Full(Full), .TX(TX)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Drive one 8N1 frame on RX; the model records it if the receiver should keep it.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      if (Enable_rx && stop && rx_model.size() < C_FIFO_DEPTH) rx_model.push_back(d);
      RX = 1'b0;
      repeat (BIT) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         repeat (BIT) @(negedge Clk);
      end
      RX = stop;
      repeat (BIT) @(negedge Clk);
      RX = 1'b1;
   endtask

   // Decode one TX frame at bit centres; ok=0 on timeout or bad start/stop.
   task automatic tx_capture(output logic [7:0] d, output int start_cyc, output logic ok);
      int w;
      w = 0; ok = 1'b1; d = 8'h00; start_cyc = 0;
      while (TX !== 1'b0 && w < 40 * BIT) begin
         @(negedge Clk);
         w++;
      end
      if (TX !== 1'b0) begin
         ok = 1'b0;
      end else begin
         start_cyc = cyc;
         repeat (BIT / 2) @(negedge Clk);
         if (TX !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge Clk);
            d[i] = TX;
         end
         repeat (BIT) @(negedge Clk);
         if (TX !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic pop_rx();
      rd_uart_en = 1'b1;
      @(negedge Clk);
      rd_uart_en = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      total++; if (TX !== 1'b1) $display("FAIL reset_tx: got %b want 1", TX); else passed++;
      total++; if (Empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", Empty); else passed++;
      total++; if (Full !== 1'b0) $display("FAIL reset_full: got %b want 0", Full); else passed++;
      total++; if (RX_data !== 8'h00) $display("FAIL reset_rxdata: got %h want 00", RX_data); else passed++;
   endtask

   task automatic test_rx_random();
      logic [7:0] d;
      Enable_rx = 1'b1;
      @(negedge Clk);
      for (int n = 0; n < 6; n++) begin
         d = (n == 0) ? 8'hA5 : 8'($urandom);
         send_frame(d, 1'b1);
         repeat (2) @(negedge Clk);
         total++;
         if (Empty !== 1'b0) $display("FAIL rx_rand_empty: got %b want 0 (byte %h)", Empty, d);
         else passed++;
         total++;
         if (RX_data !== rx_model[0]) $display("FAIL rx_rand_data: got %h want %h", RX_data, rx_model[0]);
         else passed++;
         pop_rx();
         void'(rx_model.pop_front());
         total++;
         if (Empty !== 1'b1) $display("FAIL rx_rand_pop: empty got %b want 1", Empty); else passed++;
      end
   endtask

   task automatic test_rx_rejects();
      // Short glitch on the line.
      Enable_rx = 1'b1;
      RX = 1'b0;
      repeat (3) @(negedge Clk);
      RX = 1'b1;
      repeat (2 * BIT) @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL rx_glitch: empty got %b want 1", Empty); else passed++;
      // Full frame with the receiver disabled.
      Enable_rx = 1'b0;
      send_frame(8'h5A, 1'b1);
      repeat (BIT) @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL rx_disabled: empty got %b want 1", Empty); else passed++;
      // Framing error: stop bit low.
      Enable_rx = 1'b1;
      send_frame(8'($urandom), 1'b0);
      repeat (BIT) @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL rx_framing: empty got %b want 1", Empty); else passed++;
      // Receiver disabled part-way through a frame.
      fork
         send_frame(8'hC3, 1'b1);
         begin
            repeat (4 * BIT) @(negedge Clk);
            Enable_rx = 1'b0;
         end
      join
      void'(rx_model.pop_back());
      Enable_rx = 1'b1;
      repeat (BIT) @(negedge Clk);
      total++; if (Empty !== 1'b1) $display("FAIL rx_abort: empty got %b want 1", Empty); else passed++;
   endtask

   task automatic test_rx_overflow();
      Enable_rx = 1'b1;
      for (int n = 0; n < C_FIFO_DEPTH + 2; n++) send_frame(8'($urandom), 1'b1);
      repeat (2) @(negedge Clk);
      while (rx_model.size() > 0) begin
         total++;
         if (Empty !== 1'b0 || RX_data !== rx_model[0])
            $display("FAIL rx_ovf_data: got %h (empty %b) want %h", RX_data, Empty, rx_model[0]);
         else passed++;
         pop_rx();
         void'(rx_model.pop_front());
      end
      total++; if (Empty !== 1'b1) $display("FAIL rx_ovf_drain: empty got %b want 1", Empty); else passed++;
   endtask

   task automatic test_rx_back_to_back();
      Enable_rx = 1'b1;
      fork
         for (int n = 0; n < 128; n++) send_frame(8'(n), 1'b1);
         for (int n = 0; n < 128; n++) begin
            int w;
            w = 0;
            while (Empty && w < 20 * BIT) begin
               @(negedge Clk);
               w++;
            end
            total++;
            if (Empty) $display("FAIL rx_b2b_timeout: byte %0d never arrived", n);
            else if (RX_data !== rx_model[0])
               $display("FAIL rx_b2b_data: got %h want %h", RX_data, rx_model[0]);
            else passed++;
            if (!Empty) void'(rx_model.pop_front());
            pop_rx();
         end
      join
   endtask

   task automatic test_tx_exact();
      logic [9:0] f;
      logic       bad;
      Enable_tx = 1'b1;
      f = {1'b1, 8'h3C, 1'b0};
      TX_data = 8'h3C;
      wr_uart_en = 1'b1;
      @(negedge Clk);
      wr_uart_en = 1'b0;
      total++; if (TX !== 1'b1) $display("FAIL tx_latency_early: got %b want 1", TX); else passed++;
      @(negedge Clk);
      for (int s = 0; s < 10; s++) begin
         bad = 1'b0;
         for (int j = 0; j < BIT; j++) begin
            if (TX !== f[s]) bad = 1'b1;
            @(negedge Clk);
         end
         total++;
         if (bad) $display("FAIL tx_3c_slot%0d: line got %b want %b", s, ~f[s], f[s]); else passed++;
      end
      repeat (BIT) @(negedge Clk);
      total++; if (TX !== 1'b1) $display("FAIL tx_3c_idle: got %b want 1", TX); else passed++;
   endtask

   task automatic test_tx_full();
      logic [7:0] d;
      logic       ok, bad;
      int         st, prev_st;
      Enable_tx = 1'b0;
      for (int n = 0; n <= C_FIFO_DEPTH; n++) begin
         TX_data = 8'(n);
         wr_uart_en = 1'b1;
         if (tx_model.size() < C_FIFO_DEPTH) tx_model.push_back(8'(n));
         @(negedge Clk);
         wr_uart_en = 1'b0;
         total++;
         if (Full !== (tx_model.size() == C_FIFO_DEPTH))
            $display("FAIL tx_full_flag%0d: got %b want %b", n, Full, tx_model.size() == C_FIFO_DEPTH);
         else passed++;
      end
      Enable_tx = 1'b1;
      prev_st = 0;
      for (int n = 0; n < C_FIFO_DEPTH; n++) begin
         tx_capture(d, st, ok);
         total++;
         if (!ok || d !== tx_model[0]) $display("FAIL tx_full_frame%0d: got %h ok %b want %h", n, d, ok, tx_model[0]);
         else passed++;
         void'(tx_model.pop_front());
         if (n > 0) begin
            total++;
            if (st - prev_st != 10 * BIT) $display("FAIL tx_b2b_gap%0d: got %0d want %0d", n, st - prev_st, 10 * BIT);
            else passed++;
         end
         prev_st = st;
      end
      bad = 1'b0;
      repeat (3 * BIT) begin
         @(negedge Clk);
         if (TX !== 1'b1) bad = 1'b1;
      end
      total++; if (bad) $display("FAIL tx_dropped17: line got 0 want 1"); else passed++;
      total++; if (Full !== 1'b0) $display("FAIL tx_full_after: got %b want 0", Full); else passed++;
   endtask

   task automatic test_tx_disable();
      logic [7:0] a, b, d;
      logic       ok, bad;
      int         st;
      a = 8'($urandom);
      b = 8'($urandom);
      Enable_tx = 1'b1;
      TX_data = a;
      wr_uart_en = 1'b1;
      @(negedge Clk);
      wr_uart_en = 1'b0;
      fork
         tx_capture(d, st, ok);
         begin
            repeat (2 * BIT) @(negedge Clk);
            Enable_tx = 1'b0;
            TX_data = b;
            wr_uart_en = 1'b1;
            @(negedge Clk);
            wr_uart_en = 1'b0;
         end
      join
      total++; if (!ok || d !== a) $display("FAIL tx_dis_complete: got %h ok %b want %h", d, ok, a); else passed++;
      bad = 1'b0;
      repeat (12 * BIT) begin
         @(negedge Clk);
         if (TX !== 1'b1) bad = 1'b1;
      end
      total++; if (bad) $display("FAIL tx_dis_hold: line got 0 want 1"); else passed++;
      Enable_tx = 1'b1;
      tx_capture(d, st, ok);
      total++; if (!ok || d !== b) $display("FAIL tx_dis_resume: got %h ok %b want %h", d, ok, b); else passed++;
   endtask

   task automatic test_reset_midframe();
      Enable_rx = 1'b1;
      Enable_tx = 1'b1;
      send_frame(8'h77, 1'b1);
      for (int n = 0; n < 3; n++) begin
         TX_data = 8'h00;
         wr_uart_en = 1'b1;
         @(negedge Clk);
      end
      wr_uart_en = 1'b0;
      repeat (3 * BIT) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      rx_model.delete();
      total++; if (TX !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", TX); else passed++;
      total++; if (Empty !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", Empty); else passed++;
      total++; if (RX_data !== 8'h00) $display("FAIL rst_mid_rxdata: got %h want 00", RX_data); else passed++;
      repeat (2 * BIT) @(negedge Clk);
      total++; if (TX !== 1'b1) $display("FAIL rst_mid_tx_idle: got %b want 1", TX); else passed++;
   endtask

   initial begin
      test_reset();
      test_rx_random();
      test_rx_rejects();
      test_rx_overflow();
      test_rx_back_to_back();
      test_tx_exact();
      test_tx_full();
      test_tx_disable();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter C_BAUDRATE, default 115200, serial bit rate in bits/s.
REQ-002 SHALL have parameter C_SYSTEM_FREQ, default 50000000, Clk frequency in Hz.
REQ-003 SHALL have parameter C_FIFO_DEPTH, default 16, entries per RX and TX FIFO (power of two, at least 2).
REQ-004 SHALL have ports: Clk input 1, sole clock, all logic on its rising edge.
REQ-005 Reset input 1, synchronous, active-high reset.
REQ-006 RX input 1, asynchronous serial receive line, idle high.
REQ-007 Enable_rx input 1, receiver enable.
REQ-008 rd_uart_en input 1, pops one RX FIFO entry.
REQ-009 RX_data output 8, RX FIFO head byte.
REQ-010 Empty output 1, RX FIFO empty.
REQ-011 TX_data input 8, byte to enqueue for transmit.
REQ-012 wr_uart_en input 1, pushes TX_data into TX FIFO.
REQ-013 Enable_tx input 1, transmitter enable.
REQ-014 Full output 1, TX FIFO full.
REQ-015 TX output 1, serial transmit line, idle high.

Function
REQ-016 SHALL use bit period BIT = C_SYSTEM_FREQ/C_BAUDRATE clocks (integer division; 434 at defaults); frame = 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-017 SHALL pass RX through a 2-flop synchronizer before any use; RX at reset value 1.
REQ-018 Receiver states IDLE, START, DATA, STOP; leaves IDLE only on synchronized RX 1->0 while Enable_rx=1.
REQ-019 START: after BIT/2 clocks resamples RX; 0 -> DATA, 1 -> IDLE (glitch, nothing stored).
REQ-020 DATA: samples 8 bits at BIT-clock spacing from start-bit centre, shifting LSB first; then STOP.
REQ-021 STOP: samples at stop-bit centre; 1 -> push byte into RX FIFO; 0 (framing error) -> discard byte; both -> IDLE, ready for a new start edge immediately.
REQ-022 Push into full RX FIFO SHALL be dropped; FIFO contents unchanged.
REQ-023 Enable_rx=0 SHALL hold receiver in IDLE, aborting any frame in progress without storing it; RX FIFO reads still work.
REQ-024 RX FIFO first-word-fall-through: RX_data = head entry whenever Empty=0, 8'h00 when Empty=1.
REQ-025 rd_uart_en=1 with Empty=0 SHALL pop one entry per clock; rd_uart_en with Empty=1 ignored; simultaneous push and pop both take effect.
REQ-026 wr_uart_en=1 with Full=0 SHALL push TX_data per clock; write while Full=1 dropped silently.
REQ-027 Transmitter states IDLE, START, DATA, STOP; in IDLE with Enable_tx=1 and TX FIFO non-empty pops head and enters START on the same edge.
REQ-028 TX driven from a register: 0 for BIT clocks (START), each data bit LSB first for BIT clocks, 1 for BIT clocks (STOP), then IDLE; back-to-back frames with no extra idle.
REQ-029 Latency: byte written at edge k into empty FIFO with Enable_tx=1 -> pop at edge k+1, TX=0 after edge k+1.
REQ-030 Enable_tx=0 SHALL prevent starting new frames; frame in progress completes.
REQ-031 Full/Empty SHALL update the clock after the causing push/pop; FIFO pointers wrap modulo C_FIFO_DEPTH with order preserved.

Reset
REQ-032 Reset=1 at a clock edge SHALL, regardless of state: both FIFOs empty, Empty=1, Full=0, RX_data=8'h00, TX=1, both FSMs IDLE, baud counters 0; any frame in progress abandoned.

Verification
REQ-033 Reset pulse -> TX=1, Empty=1, Full=0, RX_data=8'h00 the clock after.
REQ-034 Enable_rx=1, drive 0xA5 at 434 clocks/bit -> Empty=0 near stop-bit centre, RX_data=0xA5; 1-cycle rd_uart_en -> Empty=1.
REQ-035 Enable_tx=1, write 0x3C -> TX 0 for 434 clocks, then 0,0,1,1,1,1,0,0 each 434 clocks, then 1.
REQ-036 Enable_tx=0, write 17 bytes 0..16 -> Full=1 after 16th, 17th dropped; raise Enable_tx -> frames 0..15 in order, back-to-back.
REQ-037 RX low for 100 clocks, or full frame with Enable_rx=0, or frame with stop bit 0 -> Empty stays 1.
REQ-038 Enable_rx=1, 128 back-to-back frames 0..127, one pop per byte -> RX_data sequence 0..127, no loss.
